// File: rtl/duty_ramp_pkg.sv
// Shared types, widths and the ramp-step helper for the duty_ramp block.
// The optional DUTY_RAMP_BACKOFF_EN build is handled in duty_ramp.sv.
package duty_ramp_pkg;

  localparam int DUTY_W = 11;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRIP = 2'd2
  } ramp_state_t;

  // One rate-limited step toward tgt, done one bit wider so nothing can wrap.
  function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt,
                                                  input logic [DUTY_W-1:0] step);
    logic [DUTY_W:0] c;
    logic [DUTY_W:0] t;
    logic [DUTY_W:0] s;
    logic [DUTY_W:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, step};
    r = c;
    if (t > c) begin
      r = ((t - c) > s) ? (c + s) : t;
    end else if (t < c) begin
      r = ((c - t) > s) ? (c - s) : t;
    end
    return (r > {1'b0, DUTY_MAX}) ? DUTY_MAX : r[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/duty_ramp_if.sv
// Signal bundle between the duty_ramp block and its surroundings.
// PWM_synch is a one-clock strobe on the last clock of a PWM period; all
// duty/state updates happen on the edge where it is sampled high.
interface duty_ramp_if;
  import duty_ramp_pkg::*;

  logic              en;
  logic [DUTY_W-1:0] target;
  logic              PWM_synch;
  logic              OVR_I_blank_n;
  logic              OVR_I;
  logic [DUTY_W-1:0] duty;
  logic              at_target;
  logic              ovr_shutdown;
  ramp_state_t       dbg_state;
  logic [CNT_W-1:0]  dbg_ovr_cnt;

  modport master (
    output en, target, PWM_synch, OVR_I_blank_n, OVR_I,
    input  duty, at_target, ovr_shutdown, dbg_state, dbg_ovr_cnt
  );

  modport slave (
    input  en, target, PWM_synch, OVR_I_blank_n, OVR_I,
    output duty, at_target, ovr_shutdown, dbg_state, dbg_ovr_cnt
  );

endinterface

// File: rtl/duty_ramp_ovr_qual.sv
// Over-current qualification: blank gating, sticky per-period fault flag
// and a saturating count of consecutive faulty periods.
module ovr_qual
  import duty_ramp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             synch,
  input  logic             clr,
  input  logic             ovr_i,
  input  logic             blank_n,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);

  logic             qual;
  logic             flag_q;
  logic             flag_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    qual   = ovr_i & blank_n;
    // A fault in the synch cycle itself belongs to the period that is ending.
    flag   = flag_q | qual;
    flag_d = flag;
    cnt_d  = cnt_q;
    if (clr) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end else if (synch) begin
      flag_d = 1'b0;
      if (flag) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/duty_ramp.sv
// Rate-limited PWM duty source with over-current trip, updated only on PWM
// period boundaries. Define DUTY_RAMP_BACKOFF_EN to halve duty on non-tripping faults.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP      = 11'd8,
  parameter int                OVR_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  duty_ramp_if.slave  bus
);

  ramp_state_t       state_q;
  ramp_state_t       state_d;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_d;
  logic              at_target_q;
  logic              at_target_d;
  logic              shutdown_q;
  logic              shutdown_d;
  logic [DUTY_W-1:0] tgt_eff;
  logic              flag;
  logic [CNT_W-1:0]  cnt;
  logic              clr;
  logic              trip;

  ovr_qual u_ovr_qual (
    .clk     (clk),
    .rst     (rst),
    .synch   (bus.PWM_synch),
    .clr     (clr),
    .ovr_i   (bus.OVR_I),
    .blank_n (bus.OVR_I_blank_n),
    .flag    (flag),
    .cnt     (cnt)
  );

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    at_target_d = at_target_q;
    shutdown_d  = shutdown_q;
    clr         = 1'b0;
    tgt_eff     = bus.en ? bus.target : '0;
    trip        = flag && ((int'(cnt) + 1) >= OVR_LIMIT);
    case (state_q)
      IDLE: begin
        clr    = 1'b1;
        duty_d = '0;
        if (bus.PWM_synch && bus.en) state_d = RUN;
      end
      RUN: begin
        if (bus.PWM_synch) begin
          if (trip) begin
            state_d = TRIP;
            duty_d  = '0;
          end
`ifdef DUTY_RAMP_BACKOFF_EN
          else if (flag) begin
            duty_d = duty_q >> 1;
          end
`endif
          else begin
            duty_d = ramp_step(duty_q, tgt_eff, STEP);
          end
          // A disabled drive parks in IDLE once it has ramped all the way down.
          if (state_d == RUN && !bus.en && duty_d == '0) state_d = IDLE;
        end
      end
      TRIP: begin
        duty_d = '0;
        if (bus.PWM_synch && !bus.en) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase
    if (bus.PWM_synch) begin
      at_target_d = (state_d == RUN) && (duty_d == bus.target);
      shutdown_d  = (state_d == TRIP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      at_target_q <= 1'b0;
      shutdown_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      at_target_q <= at_target_d;
      shutdown_q  <= shutdown_d;
    end
  end

  assign bus.duty         = duty_q;
  assign bus.at_target    = at_target_q;
  assign bus.ovr_shutdown = shutdown_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_ovr_cnt  = cnt;

endmodule
